// File: rtl/usb_tx_pkg.sv
// rtl/usb_tx_pkg.sv - USB line state types and framing constants shared by usb_tx and usb_rx
package usb_tx_pkg;

    // Full-speed encoding: J = D+ high, K = D- high
    typedef enum logic [1:0] {
        D_SE0 = 2'b00,
        D_K   = 2'b01,
        D_J   = 2'b10,
        D_SE1 = 2'b11
    } d_port_t;

    localparam logic [7:0] USB_SYNC      = 8'h80;
    localparam int         USB_STUFF_LEN = 6;

endpackage

// File: rtl/usb_nrzi_stuff.sv
// rtl/usb_nrzi_stuff.sv - NRZI line level and ones counter with stuff-bit request
module usb_nrzi_stuff
    import usb_tx_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic bit_en,
    input  logic bit_in,
    input  logic stuff_req,
    output logic level_nxt,
    output logic stuff_now
);

    logic       level;
    logic [2:0] ones;
    logic       base_level;
    logic [2:0] base_ones;
    logic       toggle;

    // level is 1 for J; clear restarts from idle J so a frame start and its first bit share an edge
    always_comb begin
        base_level = clear ? 1'b1 : level;
        base_ones  = clear ? 3'd0 : ones;
        toggle     = stuff_req || !bit_in;
        level_nxt  = toggle ? !base_level : base_level;
    end

    assign stuff_now = (ones == 3'(USB_STUFF_LEN));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level <= 1'b1;
            ones  <= 3'd0;
        end else if (bit_en) begin
            level <= level_nxt;
            ones  <= toggle ? 3'd0 : base_ones + 3'd1;
        end else if (clear) begin
            level <= 1'b1;
            ones  <= 3'd0;
        end
    end

endmodule

// File: rtl/usb_tx.sv
// rtl/usb_tx.sv - USB 1.1 line transmitter: SYNC, NRZI, bit stuffing, EOP and inter-packet gap
module usb_tx
    import usb_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 2,
    parameter bit LOW_SPEED    = 1'b0,
    parameter int MIN_GAP_BITS = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [1:0] d,
    output logic       oe,
    output logic       active
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int GW = (MIN_GAP_BITS > 1) ? $clog2(MIN_GAP_BITS) : 1;
    localparam logic [1:0] LINE_J = LOW_SPEED ? D_K : D_J;
    localparam logic [1:0] LINE_K = LOW_SPEED ? D_J : D_K;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_DATA,
        S_EOP_SE0,
        S_EOP_J,
        S_GAP
    } state_t;

    state_t        state;
    logic [TW-1:0] bit_cnt;
    logic [6:0]    shreg;
    logic [2:0]    bit_idx;
    logic          eop_cnt;
    logic [GW-1:0] gap_cnt;

    logic       bit_en;
    logic       in_frame;
    logic       byte_done;
    logic       gap_done;
    logic       start;
    logic       end_frame;
    logic       nrzi_adv;
    logic       nrzi_bit;
    logic       level_nxt;
    logic       stuff_now;
    logic [1:0] drive_lv;

    assign bit_en    = (bit_cnt == TW'(CLKS_PER_BIT - 1));
    assign in_frame  = (state == S_SYNC) || (state == S_DATA);
    assign byte_done = (bit_idx == 3'd7);
    assign gap_done  = (state == S_GAP) && bit_en && (gap_cnt == GW'(MIN_GAP_BITS - 1));
    assign start     = tx_valid && ((state == S_IDLE) || gap_done);

    // A pending stuff bit always goes out before the byte boundary is honoured
    assign tx_ready  = in_frame && bit_en && byte_done && !stuff_now && tx_valid;
    assign end_frame = in_frame && bit_en && byte_done && !stuff_now && !tx_valid;
    assign nrzi_adv  = start || (in_frame && bit_en && !end_frame);
    assign nrzi_bit  = start ? USB_SYNC[0] : (byte_done ? tx_data[0] : shreg[0]);
    assign drive_lv  = level_nxt ? LINE_J : LINE_K;

    usb_nrzi_stuff u_nrzi (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (start),
        .bit_en    (nrzi_adv),
        .bit_in    (nrzi_bit),
        .stuff_req (in_frame && stuff_now),
        .level_nxt (level_nxt),
        .stuff_now (stuff_now)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt <= '0;
        end else if (start || bit_en) begin
            bit_cnt <= '0;
        end else begin
            bit_cnt <= bit_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            d       <= LINE_J;
            oe      <= 1'b0;
            active  <= 1'b0;
            shreg   <= '0;
            bit_idx <= '0;
            eop_cnt <= 1'b0;
            gap_cnt <= '0;
        end else if (start) begin
            state   <= S_SYNC;
            oe      <= 1'b1;
            active  <= 1'b1;
            shreg   <= USB_SYNC[7:1];
            bit_idx <= '0;
            d       <= drive_lv;
        end else begin
            case (state)
                S_SYNC, S_DATA: begin
                    if (bit_en) begin
                        if (stuff_now) begin
                            d <= drive_lv;
                        end else if (!byte_done) begin
                            shreg   <= {1'b0, shreg[6:1]};
                            bit_idx <= bit_idx + 3'd1;
                            d       <= drive_lv;
                        end else if (tx_valid) begin
                            state   <= S_DATA;
                            shreg   <= tx_data[7:1];
                            bit_idx <= '0;
                            d       <= drive_lv;
                        end else begin
                            state   <= S_EOP_SE0;
                            eop_cnt <= 1'b0;
                            d       <= D_SE0;
                        end
                    end
                end
                S_EOP_SE0: begin
                    if (bit_en) begin
                        if (eop_cnt) begin
                            state <= S_EOP_J;
                            d     <= LINE_J;
                        end else begin
                            eop_cnt <= 1'b1;
                        end
                    end
                end
                S_EOP_J: begin
                    if (bit_en) begin
                        oe      <= 1'b0;
                        active  <= 1'b0;
                        gap_cnt <= '0;
                        state   <= (MIN_GAP_BITS == 0) ? S_IDLE : S_GAP;
                    end
                end
                S_GAP: begin
                    // tx_valid is only looked at once the whole gap has elapsed
                    if (gap_done) begin
                        state <= S_IDLE;
                    end else if (bit_en) begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_tx.sv
// tb/tb_usb_tx.sv - directed and random line-level checks of usb_tx against a bench-side receiver
module tb_usb_tx;
    import usb_tx_pkg::*;

    localparam int CPB    = 2;
    localparam int LS_CPB = 16;
    localparam int GAP    = 2;
    localparam logic [1:0] J   = 2'b10;
    localparam logic [1:0] K   = 2'b01;
    localparam logic [1:0] SE0 = 2'b00;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [1:0] d;
    logic       oe;
    logic       active;
    logic [7:0] ls_data;
    logic       ls_valid;
    logic       ls_ready;
    logic [1:0] ls_d;
    logic       ls_oe;
    logic       ls_active;

    always #5 clk = ~clk;

    usb_tx #(.CLKS_PER_BIT(CPB), .LOW_SPEED(1'b0), .MIN_GAP_BITS(GAP)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .d        (d),
        .oe       (oe),
        .active   (active)
    );

    usb_tx #(.CLKS_PER_BIT(LS_CPB), .LOW_SPEED(1'b1), .MIN_GAP_BITS(GAP)) dut_ls (
        .clk      (clk),
        .reset_n  (reset_n),
        .tx_data  (ls_data),
        .tx_valid (ls_valid),
        .tx_ready (ls_ready),
        .d        (ls_d),
        .oe       (ls_oe),
        .active   (ls_active)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];
    logic [7:0] pkt[$];
    logic [1:0] lv_q[$];
    logic [1:0] ls_q[$];

    bit         in_pkt    = 1'b0;
    bit         rst_abort = 1'b0;
    int         pcyc, nb, ones, se0_bit, ready_cnt, ready_at;
    int         pkt_done = 0;
    int         gap_cyc  = 0;
    int         last_gap = 0;
    logic [1:0] prev_lv;
    logic [7:0] sh;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int wave_errs(input string s, input logic [1:0] jl, input logic [1:0] kl,
                                     input int cpb, input logic [1:0] q[$]);
        int         errs = 0;
        byte        c;
        logic [1:0] e;
        if (q.size() != s.len() * cpb) errs++;
        for (int i = 0; i < q.size() && i < s.len() * cpb; i++) begin
            c = s[i / cpb];
            if (c == "J") e = jl;
            else if (c == "K") e = kl;
            else e = SE0;
            if (q[i] !== e) errs++;
        end
        return errs;
    endfunction

    // Receiver model: one sample per bit, NRZI decode, destuff, bytes checked against the scoreboard
    task automatic mon_bit(input int b);
        logic bitv;
        if (se0_bit >= 0) begin
            if (b - se0_bit < 2) chk("eop_se0", 32'(d), 32'(SE0));
            else chk("eop_j", 32'(d), 32'(J));
        end else if (d == SE0) begin
            se0_bit = b;
            chk("eop_on_byte_boundary", 32'(nb % 8), 0);
        end else begin
            bitv    = (d == prev_lv);
            prev_lv = d;
            if (ones == 6) begin
                chk("stuff_bit_toggles", 32'(bitv), 0);
                ones = 0;
            end else begin
                ones = bitv ? ones + 1 : 0;
                sh   = {bitv, sh[7:1]};
                nb++;
                if (nb % 8 == 0) begin
                    if (nb == 8) begin
                        chk("sync_pattern", 32'(sh), 32'(USB_SYNC));
                    end else begin
                        chk("byte_expected", 32'(exp_q.size() > 0), 1);
                        if (exp_q.size() > 0) chk("byte_value", 32'(sh), 32'(exp_q.pop_front()));
                    end
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (tx_ready) chk("ready_only_in_frame", 32'(oe), 1);
        if (oe) begin
            if (!in_pkt) begin
                in_pkt    = 1'b1;
                pcyc      = 0;
                nb        = 0;
                ones      = 0;
                se0_bit   = -1;
                prev_lv   = J;
                ready_cnt = 0;
                ready_at  = -1;
                last_gap  = gap_cyc;
                lv_q.delete();
                chk("active_with_oe", 32'(active), 1);
            end
            lv_q.push_back(d);
            if (tx_ready) begin
                ready_cnt++;
                ready_at = pcyc;
            end
            if (pcyc % CPB == 0) mon_bit(pcyc / CPB);
            pcyc++;
        end else begin
            if (in_pkt) begin
                in_pkt  = 1'b0;
                gap_cyc = 0;
                if (!rst_abort) begin
                    chk("active_drops_with_oe", 32'(active), 0);
                    chk("eop_j_ends_frame", 32'(pcyc), 32'((se0_bit + 3) * CPB));
                end
                pkt_done++;
            end
            gap_cyc++;
        end
    end

    always @(negedge clk) if (ls_oe) ls_q.push_back(ls_d);

    task automatic send_pkt(input int rst_byte);
        int k   = 0;
        int cyc = 0;
        foreach (pkt[i]) exp_q.push_back(pkt[i]);
        tx_data  = pkt[0];
        tx_valid = 1'b1;
        while (k < pkt.size() && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (tx_ready) begin
                @(posedge clk);
                #1;
                k++;
                if (k < pkt.size()) tx_data = pkt[k];
                if (k == rst_byte) begin
                    repeat (5) @(posedge clk);
                    #2;
                    rst_abort = 1'b1;
                    reset_n   = 1'b0;
                    #1;
                    chk("rst_oe", 32'(oe), 0);
                    chk("rst_d", 32'(d), 32'(J));
                    chk("rst_active", 32'(active), 0);
                    chk("rst_ready", 32'(tx_ready), 0);
                    tx_valid = 1'b0;
                    return;
                end
            end
        end
        chk("send_no_stall", 32'(k), 32'(pkt.size()));
        tx_valid = 1'b0;
    endtask

    task automatic wait_pkts(input int target);
        int cyc = 0;
        while (pkt_done < target && cyc < 20000) begin
            @(posedge clk);
            cyc++;
        end
        chk("packet_completes", 32'(pkt_done >= target), 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        int n;
        int cyc;

        reset_n  = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        ls_valid = 1'b0;
        ls_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_d", 32'(d), 32'(J));
        chk("reset_oe", 32'(oe), 0);
        chk("reset_active", 32'(active), 0);
        chk("reset_ready", 32'(tx_ready), 0);
        chk("reset_ls_d", 32'(ls_d), 32'(K));
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_oe", 32'(oe), 0);

        // ACK handshake byte
        pkt  = {8'hD2};
        base = pkt_done;
        send_pkt(-1);
        wait_pkts(base + 1);
        chk("ack_wave_errors", 32'(wave_errs("KJKJKJKKJJKJJKKK00J", J, K, CPB, lv_q)), 0);
        chk("ack_oe_cycles", 32'(lv_q.size()), 38);
        chk("ack_ready_pulses", 32'(ready_cnt), 1);
        chk("ack_ready_at_sync_end", 32'(ready_at), 32'(8 * CPB - 1));
        chk("ack_bytes_drained", 32'(exp_q.size()), 0);

        // FF FF: stuffing after byte1 bit4 and byte2 bit2
        pkt  = {8'hFF, 8'hFF};
        base = pkt_done;
        send_pkt(-1);
        wait_pkts(base + 1);
        chk("ffff_se0_bit", 32'(se0_bit), 26);
        chk("ffff_ready_pulses", 32'(ready_cnt), 2);
        chk("ffff_bytes_drained", 32'(exp_q.size()), 0);

        // FC: stuff bit owed after the last data bit goes out before SE0
        pkt  = {8'hFC};
        base = pkt_done;
        send_pkt(-1);
        wait_pkts(base + 1);
        chk("fc_se0_bit", 32'(se0_bit), 17);
        chk("fc_bytes_drained", 32'(exp_q.size()), 0);

        // Reset during byte 2 of a 3-byte packet, then a clean ACK
        pkt  = {8'hA5, 8'h3C, 8'h0F};
        base = pkt_done;
        send_pkt(2);
        wait_pkts(base + 1);
        exp_q.delete();
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_abort = 1'b0;
        pkt  = {8'hD2};
        base = pkt_done;
        send_pkt(-1);
        wait_pkts(base + 1);
        chk("post_rst_ack_wave_errors", 32'(wave_errs("KJKJKJKKJJKJJKKK00J", J, K, CPB, lv_q)), 0);

        // tx_valid raised during EOP: second packet waits out the full gap
        pkt  = {8'hD2};
        base = pkt_done;
        send_pkt(-1);
        cyc = 0;
        while (se0_bit < 0 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        chk("first_eop_seen", 32'(se0_bit >= 0), 1);
        pkt = {8'h4B, 8'h11};
        send_pkt(-1);
        wait_pkts(base + 2);
        chk("gap_cycles", 32'(last_gap), 32'(GAP * CPB));
        chk("b2b_ready_pulses", 32'(ready_cnt), 2);
        chk("b2b_bytes_drained", 32'(exp_q.size()), 0);

        // Random loopback packets
        for (int p = 0; p < 4; p++) begin
            n = $urandom_range(1, 64);
            pkt.delete();
            for (int i = 0; i < n; i++) pkt.push_back(8'($urandom));
            base = pkt_done;
            send_pkt(-1);
            wait_pkts(base + 1);
            chk("rand_bytes_drained", 32'(exp_q.size()), 0);
            chk("rand_ready_pulses", 32'(ready_cnt), 32'(n));
        end

        // Low speed: J/K swapped, 16 clk per bit
        ls_q.delete();
        ls_data  = 8'hD2;
        ls_valid = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!ls_ready && cyc < 2000);
        chk("ls_ready_pulse", 32'(ls_ready), 1);
        @(posedge clk);
        #1;
        ls_valid = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while ((ls_oe || ls_q.size() == 0) && cyc < 2000);
        chk("ls_active_drops", 32'(ls_active), 0);
        chk("ls_wave_errors", 32'(wave_errs("KJKJKJKKJJKJJKKK00J", K, J, LS_CPB, ls_q)), 0);
        chk("ls_oe_cycles", 32'(ls_q.size()), 32'(19 * LS_CPB));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
